// File: rtl/seg7_scan_pkg.sv
// Shared constants for the multiplexed 7-segment scanner: digit count,
// blank pattern, the active-low hex segment table and the display register layout.
package seg7_scan_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;

  // Active-low, bit 0 = CA .. bit 6 = CG; index is the hex nibble
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef struct packed {
    logic [31:0] data;
    logic [7:0]  dp;
    logic [7:0]  en;
  } disp_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_decode
  import seg7_scan_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_HEX[nib];
  end

endmodule

// File: rtl/seg7_scan.sv
// Eight-digit 7-segment scanner with blank-before-show slots and
// frame-synchronous double-buffered display updates.
module seg7_scan
  import seg7_scan_pkg::*;
#(
  parameter int unsigned SLOT_CYC  = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input  logic        CLK,
  input  logic        CPU_RESET_N,
  input  logic [31:0] DATA_I,
  input  logic [7:0]  DP_I,
  input  logic [7:0]  EN_I,
  input  logic        LOAD_I,
  output logic [7:0]  AN_O,
  output logic [6:0]  SEG_O,
  output logic        DP_O,
  output logic        PEND_O,
  output logic        FRAME_O
);

  localparam int unsigned CW = $clog2(SLOT_CYC);
  localparam int unsigned DW = $clog2(NUM_DIGITS);

  logic [CW-1:0] slot_cnt;
  logic [DW-1:0] digit;
  disp_t         act;
  disp_t         pnd;
  logic [3:0]    nib;
  logic [6:0]    seg_pat;
  logic          slot_end;
  logic          boundary;
  logic          blank;

  always_comb begin
    nib      = act.data[{digit, 2'b00} +: 4];
    slot_end = (slot_cnt == CW'(SLOT_CYC - 1));
    boundary = (slot_cnt == '0) && (digit == '0);
    blank    = (slot_cnt < CW'(BLANK_CYC));
  end

  seg7_decode u_decode (
    .nib (nib),
    .seg (seg_pat)
  );

  // Outputs are registered from the current counter state, so they trail the
  // counter by one cycle; the boundary copy lands in a blank cycle and is
  // therefore already in place before the first show cycle of digit 0.
  always_ff @(posedge CLK or negedge CPU_RESET_N) begin
    if (!CPU_RESET_N) begin
      slot_cnt <= '0;
      digit    <= '0;
      act      <= '0;
      pnd      <= '0;
      PEND_O   <= 1'b0;
      FRAME_O  <= 1'b0;
      AN_O     <= '1;
      SEG_O    <= SEG_BLANK;
      DP_O     <= 1'b1;
    end else begin
      if (slot_end) begin
        slot_cnt <= '0;
        digit    <= digit + DW'(1);
      end else begin
        slot_cnt <= slot_cnt + CW'(1);
      end

      if (boundary && PEND_O) begin
        act <= pnd;
      end

      if (LOAD_I) begin
        pnd    <= '{data: DATA_I, dp: DP_I, en: EN_I};
        PEND_O <= 1'b1;
      end else if (boundary) begin
        PEND_O <= 1'b0;
      end

      FRAME_O <= boundary;

      if (blank) begin
        AN_O  <= '1;
        SEG_O <= SEG_BLANK;
        DP_O  <= 1'b1;
      end else begin
        AN_O  <= act.en[digit] ? ~(8'b1 << digit) : 8'hFF;
        SEG_O <= seg_pat;
        DP_O  <= ~act.dp[digit];
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan.sv
// Directed self-checking bench for seg7_scan with SLOT_CYC=8, BLANK_CYC=2.
module tb_seg7_scan;

  logic        CLK = 1'b0;
  logic        CPU_RESET_N = 1'b0;
  logic [31:0] DATA_I = '0;
  logic [7:0]  DP_I = '0;
  logic [7:0]  EN_I = '0;
  logic        LOAD_I = 1'b0;
  logic [7:0]  AN_O;
  logic [6:0]  SEG_O;
  logic        DP_O;
  logic        PEND_O;
  logic        FRAME_O;

  int passed = 0;
  int total  = 0;

  logic [6:0] hex_seg [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  seg7_scan #(.SLOT_CYC(8), .BLANK_CYC(2)) dut (
    .CLK         (CLK),
    .CPU_RESET_N (CPU_RESET_N),
    .DATA_I      (DATA_I),
    .DP_I        (DP_I),
    .EN_I        (EN_I),
    .LOAD_I      (LOAD_I),
    .AN_O        (AN_O),
    .SEG_O       (SEG_O),
    .DP_O        (DP_O),
    .PEND_O      (PEND_O),
    .FRAME_O     (FRAME_O)
  );

  always #5 CLK = ~CLK;

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Advance until FRAME_O is seen (at least one cycle), bounded.
  task automatic wait_frame(output bit ok);
    int n = 0;
    ok = 1'b0;
    do begin
      tick();
      n++;
    end while (!FRAME_O && n < 200);
    ok = FRAME_O;
  endtask

  task automatic load(input logic [31:0] d, input logic [7:0] dp, input logic [7:0] en);
    DATA_I = d; DP_I = dp; EN_I = en; LOAD_I = 1'b1;
    tick();
    LOAD_I = 1'b0;
  endtask

  task automatic test_reset;
    tick(3);
    total++; if (AN_O !== 8'hFF) $display("FAIL reset_an got=%h exp=ff", AN_O); else passed++;
    total++; if (SEG_O !== 7'h7F) $display("FAIL reset_seg got=%h exp=7f", SEG_O); else passed++;
    total++; if (DP_O !== 1'b1) $display("FAIL reset_dp got=%b exp=1", DP_O); else passed++;
    total++; if (PEND_O !== 1'b0) $display("FAIL reset_pend got=%b exp=0", PEND_O); else passed++;
    total++; if (FRAME_O !== 1'b0) $display("FAIL reset_frame got=%b exp=0", FRAME_O); else passed++;
    CPU_RESET_N = 1'b1;
    tick();
    total++; if (FRAME_O !== 1'b1) $display("FAIL release_frame got=%b exp=1", FRAME_O); else passed++;
  endtask

  task automatic test_load_digit0;
    bit ok;
    load(32'h76543210, 8'h00, 8'hFF);
    total++; if (PEND_O !== 1'b1) $display("FAIL load_pend got=%b exp=1", PEND_O); else passed++;
    wait_frame(ok);
    total++; if (!ok) $display("FAIL load_frame_timeout got=0 exp=1"); else passed++;
    total++; if (PEND_O !== 1'b0) $display("FAIL load_pend_clr got=%b exp=0", PEND_O); else passed++;
    for (int s = 0; s < 8; s++) begin
      if (s < 2) begin
        total++; if (AN_O !== 8'hFF || SEG_O !== 7'h7F)
          $display("FAIL d0_blank s=%0d got an=%h seg=%h exp an=ff seg=7f", s, AN_O, SEG_O); else passed++;
      end else begin
        total++; if (AN_O !== 8'hFE || SEG_O !== 7'h40 || DP_O !== 1'b1)
          $display("FAIL d0_show s=%0d got an=%h seg=%h dp=%b exp an=fe seg=40 dp=1", s, AN_O, SEG_O, DP_O); else passed++;
      end
      tick();
    end
  endtask

  task automatic test_full_frame;
    bit ok;
    logic [31:0] d = 32'hFEDCBA98;
    logic [7:0] exp_an;
    logic [6:0] exp_seg;
    load(d, 8'h00, 8'hFF);
    wait_frame(ok);
    total++; if (!ok) $display("FAIL full_frame_timeout got=0 exp=1"); else passed++;
    for (int p = 0; p < 64; p++) begin
      int dg = p / 8;
      int s  = p % 8;
      exp_an  = (s < 2) ? 8'hFF : ~(8'b1 << dg);
      exp_seg = (s < 2) ? 7'h7F : hex_seg[d[dg*4 +: 4]];
      total++; if (AN_O !== exp_an || SEG_O !== exp_seg || FRAME_O !== (p == 0))
        $display("FAIL full_frame p=%0d got an=%h seg=%h fr=%b exp an=%h seg=%h fr=%b",
                 p, AN_O, SEG_O, FRAME_O, exp_an, exp_seg, (p == 0)); else passed++;
      tick();
    end
    total++; if (FRAME_O !== 1'b1) $display("FAIL frame_period got=%b exp=1", FRAME_O); else passed++;
  endtask

  task automatic test_en_dp;
    bit ok;
    logic [31:0] d = 32'h89ABCDEF;
    logic [7:0] exp_an;
    logic exp_dp;
    load(d, 8'h04, 8'h05);
    wait_frame(ok);
    total++; if (!ok) $display("FAIL en_dp_timeout got=0 exp=1"); else passed++;
    for (int p = 0; p < 64; p++) begin
      int dg = p / 8;
      int s  = p % 8;
      exp_an = (s >= 2 && dg == 0) ? 8'hFE : (s >= 2 && dg == 2) ? 8'hFB : 8'hFF;
      exp_dp = !(s >= 2 && dg == 2);
      total++; if (AN_O !== exp_an || DP_O !== exp_dp)
        $display("FAIL en_dp p=%0d got an=%h dp=%b exp an=%h dp=%b", p, AN_O, DP_O, exp_an, exp_dp); else passed++;
      if (s >= 2 && (dg == 0 || dg == 2)) begin
        total++; if (SEG_O !== hex_seg[d[dg*4 +: 4]])
          $display("FAIL en_dp_seg p=%0d got=%h exp=%h", p, SEG_O, hex_seg[d[dg*4 +: 4]]); else passed++;
      end
      tick();
    end
  endtask

  task automatic test_back_to_back;
    bit ok;
    // Now at frame position 0 with EN=05 active.
    tick(10);
    load(32'h33333333, 8'h00, 8'hFF);
    total++; if (PEND_O !== 1'b1) $display("FAIL b2b_pend_a got=%b exp=1", PEND_O); else passed++;
    tick(9);
    total++; if (AN_O !== 8'hFB) $display("FAIL b2b_no_midframe got=%h exp=fb", AN_O); else passed++;
    tick(43);
    load(32'hCCCCCCCC, 8'hFF, 8'hFF);
    total++; if (FRAME_O !== 1'b1 || PEND_O !== 1'b1)
      $display("FAIL b2b_boundary got fr=%b pend=%b exp fr=1 pend=1", FRAME_O, PEND_O); else passed++;
    for (int p = 0; p < 64; p++) begin
      if (p % 8 >= 2) begin
        total++; if (SEG_O !== 7'h30 || PEND_O !== 1'b1 || DP_O !== 1'b1)
          $display("FAIL b2b_frame_a p=%0d got seg=%h pend=%b dp=%b exp seg=30 pend=1 dp=1",
                   p, SEG_O, PEND_O, DP_O); else passed++;
      end
      tick();
    end
    total++; if (FRAME_O !== 1'b1 || PEND_O !== 1'b0)
      $display("FAIL b2b_boundary2 got fr=%b pend=%b exp fr=1 pend=0", FRAME_O, PEND_O); else passed++;
    for (int p = 0; p < 64; p++) begin
      if (p % 8 >= 2) begin
        total++; if (SEG_O !== 7'h46 || DP_O !== 1'b0)
          $display("FAIL b2b_frame_b p=%0d got seg=%h dp=%b exp seg=46 dp=0", p, SEG_O, DP_O); else passed++;
      end
      if (p < 63) tick();
    end
    // Load on the boundary with nothing pending: current frame keeps B.
    load(32'h55555555, 8'h00, 8'hFF);
    total++; if (FRAME_O !== 1'b1 || PEND_O !== 1'b1)
      $display("FAIL idle_boundary got fr=%b pend=%b exp fr=1 pend=1", FRAME_O, PEND_O); else passed++;
    tick(2);
    total++; if (SEG_O !== 7'h46) $display("FAIL idle_boundary_keep got=%h exp=46", SEG_O); else passed++;
    wait_frame(ok);
    total++; if (!ok || PEND_O !== 1'b0)
      $display("FAIL idle_boundary_apply got ok=%b pend=%b exp ok=1 pend=0", ok, PEND_O); else passed++;
    tick(2);
    total++; if (SEG_O !== 7'h12) $display("FAIL idle_boundary_new got=%h exp=12", SEG_O); else passed++;
  endtask

  task automatic test_reset_mid;
    bit ok;
    wait_frame(ok);
    total++; if (!ok) $display("FAIL rst_mid_timeout got=0 exp=1"); else passed++;
    tick(2);
    load(32'h88888888, 8'hFF, 8'hFF);
    tick(41);
    total++; if (AN_O !== 8'hDF || PEND_O !== 1'b1)
      $display("FAIL rst_mid_pre got an=%h pend=%b exp an=df pend=1", AN_O, PEND_O); else passed++;
    #1 CPU_RESET_N = 1'b0;
    #1;
    total++; if (AN_O !== 8'hFF || SEG_O !== 7'h7F || DP_O !== 1'b1 || PEND_O !== 1'b0 || FRAME_O !== 1'b0)
      $display("FAIL rst_async got an=%h seg=%h dp=%b pend=%b fr=%b exp an=ff seg=7f dp=1 pend=0 fr=0",
               AN_O, SEG_O, DP_O, PEND_O, FRAME_O); else passed++;
    tick(2);
    #2 CPU_RESET_N = 1'b1;
    tick();
    total++; if (FRAME_O !== 1'b1) $display("FAIL rst_mid_frame got=%b exp=1", FRAME_O); else passed++;
    for (int p = 0; p < 66; p++) begin
      total++; if (AN_O !== 8'hFF || PEND_O !== 1'b0)
        $display("FAIL rst_mid_blank p=%0d got an=%h pend=%b exp an=ff pend=0", p, AN_O, PEND_O); else passed++;
      if (p == 64) begin
        total++; if (FRAME_O !== 1'b1) $display("FAIL rst_mid_frame2 got=%b exp=1", FRAME_O); else passed++;
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_load_digit0();
    test_full_frame();
    test_en_dp();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
